// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : button_pkg
//  Purpose  : Shared types and default constants for the push-button decoder:
//             press-classifier state encoding and default cycle counts.
//  Revision : 1.0 - initial release
// ============================================================================
package button_pkg;

    // Press-classifier states; explicit 3-bit encoding keeps the register
    // width fixed regardless of tool enum sizing.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        HELD   = 3'd2,
        GAP    = 3'd3,
        PRESS2 = 3'd4
    } btn_state_t;

    localparam int unsigned C_DEBOUNCE_CYCLES = 4;
    localparam int unsigned C_LONG_CYCLES     = 20;
    localparam int unsigned C_DOUBLE_GAP      = 10;
    localparam int unsigned C_CNT_W           = 8;

endpackage : button_pkg
`default_nettype wire

// File: rtl/button_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : button_if
//  Purpose  : Groups the raw button input and the decoded level/event
//             outputs. The decoder uses the slave view; the stimulus / mode
//             select logic uses the master view.
//  Revision : 1.0 - initial release
// ============================================================================
interface button_if;

    logic btn_raw;
    logic btn_level;
    logic short_press;
    logic long_press;
    logic double_press;
    logic busy;

    modport master (
        output btn_raw,
        input  btn_level,
        input  short_press,
        input  long_press,
        input  double_press,
        input  busy
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output short_press,
        output long_press,
        output double_press,
        output busy
    );

endinterface : button_if
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : Two-flop synchroniser followed by a consecutive-sample
//             debouncer. btn_level only flips after DEBOUNCE_CYCLES
//             consecutive synchronised samples disagree with it.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = C_CNT_W
) (
    input  wire logic clk,
    input  wire logic rstbtn_n,
    input  wire logic btn_raw,
    output logic      btn_level
);

    localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rstbtn_n) begin
        if (!rstbtn_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= btn_raw;
            r_s2 <= r_s1;
        end
    end

    // Count consecutive disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rstbtn_n) begin
        if (!rstbtn_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_s2 == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == c_DB_LAST) begin
            r_level <= r_s2;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign btn_level = r_level;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/button_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : button_decoder
//  Purpose  : Turns a raw, bouncing push-button into a debounced level and
//             single-cycle short / long / double press event pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module button_decoder
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = C_LONG_CYCLES,
    parameter int unsigned DOUBLE_GAP      = C_DOUBLE_GAP,
    parameter int unsigned CNT_W           = C_CNT_W
) (
    input  wire logic clk,
    input  wire logic rstbtn_n,
    button_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(DOUBLE_GAP - 1);

    logic             w_level;
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_tcnt;
    logic             r_short;
    logic             r_long;
    logic             r_double;
    logic             r_busy;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk       (clk),
        .rstbtn_n  (rstbtn_n),
        .btn_raw   (bus.btn_raw),
        .btn_level (w_level)
    );

    // Press classifier: pulses default low each cycle and are raised only on
    // the classifying transition; busy tracks the next state leaving IDLE.
    always_ff @(posedge clk or negedge rstbtn_n) begin
        if (!rstbtn_n) begin
            r_state  <= IDLE;
            r_tcnt   <= '0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_level) begin
                        r_state <= PRESS1;
                        r_tcnt  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                PRESS1: begin
                    if (!w_level) begin
                        r_state <= GAP;
                        r_tcnt  <= '0;
                    end else if (r_tcnt == c_LONG_LAST) begin
                        r_long  <= 1'b1;
                        r_state <= HELD;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                HELD: begin
                    // Wait out the rest of the hold without further events.
                    if (!w_level) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                GAP: begin
                    // A second press wins over the timeout in the same cycle.
                    if (w_level) begin
                        r_state <= PRESS2;
                        r_tcnt  <= '0;
                    end else if (r_tcnt == c_GAP_LAST) begin
                        r_short <= 1'b1;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                PRESS2: begin
                    if (!w_level) begin
                        r_double <= 1'b1;
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                    end else if (r_tcnt == c_LONG_LAST) begin
                        r_double <= 1'b1;
                        r_state  <= HELD;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.btn_level    = w_level;
    assign bus.short_press  = r_short;
    assign bus.long_press   = r_long;
    assign bus.double_press = r_double;
    assign bus.busy         = r_busy;

endmodule : button_decoder
`default_nettype wire

// File: tb/tb_button_decoder.sv
`timescale 1ns/1ps
module tb_button_decoder;

    logic clk;
    logic rstbtn_n;
    button_if bus ();

    button_decoder dut (
        .clk      (clk),
        .rstbtn_n (rstbtn_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Edge counter: edge k sets cyc to k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled mid-cycle.
    int n_short = 0, n_long = 0, n_double = 0, n_rise = 0, n_multi = 0;
    int t_short = -1, t_long = -1, t_double = -1, t_rise = -1, t_fall = -1, t_busy_fall = -1;
    logic prev_level = 1'b0;
    logic prev_busy  = 1'b0;
    always @(negedge clk) begin
        if (bus.short_press)  begin n_short  <= n_short + 1;  t_short  <= cyc; end
        if (bus.long_press)   begin n_long   <= n_long + 1;   t_long   <= cyc; end
        if (bus.double_press) begin n_double <= n_double + 1; t_double <= cyc; end
        if ((32'(bus.short_press) + 32'(bus.long_press) + 32'(bus.double_press)) > 1)
            n_multi <= n_multi + 1;
        if (bus.btn_level && !prev_level) begin n_rise <= n_rise + 1; t_rise <= cyc; end
        if (!bus.btn_level && prev_level) t_fall <= cyc;
        if (!bus.busy && prev_busy) t_busy_fall <= cyc;
        prev_level <= bus.btn_level;
        prev_busy  <= bus.busy;
    end

    // Drive btn_raw to v for n edges; returns 1 time unit after the last edge.
    task automatic hold(input logic v, input int n);
        bus.btn_raw = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Release the button and wait (bounded) until decoder is idle and level low.
    task automatic wait_idle();
        int k;
        hold(1'b0, 8);
        k = 0;
        while ((bus.busy || bus.btn_level) && k < 300) begin
            hold(1'b0, 1);
            k++;
        end
        hold(1'b0, 3);
        total++;
        if (bus.busy !== 1'b0 || bus.btn_level !== 1'b0) begin
            bad++;
            $display("FAIL idle_timeout: got busy=%0b level=%0b want 0/0", bus.busy, bus.btn_level);
        end
    endtask

    task automatic test_reset();
        rstbtn_n = 1'b0;
        bus.btn_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.btn_level !== 1'b0) begin bad++; $display("FAIL rst_level: got %0b want 0", bus.btn_level); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
        total++; if ({bus.short_press, bus.long_press, bus.double_press} !== 3'b000) begin
            bad++; $display("FAIL rst_pulses: got %b want 000", {bus.short_press, bus.long_press, bus.double_press}); end
        bus.btn_raw = 1'b0;
        rstbtn_n = 1'b1;
        hold(1'b0, 10);
        total++; if (n_rise !== 0) begin bad++; $display("FAIL rst_release_rise: got %0d want 0", n_rise); end
        total++; if (n_short + n_long + n_double !== 0) begin
            bad++; $display("FAIL rst_release_pulse: got %0d want 0", n_short + n_long + n_double); end
    endtask

    task automatic test_glitch();
        int b_rise, b_pulse, b_short, r;
        b_rise = n_rise; b_pulse = n_short + n_long + n_double; b_short = n_short;
        hold(1'b1, 3);
        hold(1'b0, 15);
        total++; if (n_rise !== b_rise) begin bad++; $display("FAIL glitch3_level: got rises=%0d want %0d", n_rise, b_rise); end
        total++; if (n_short + n_long + n_double !== b_pulse) begin
            bad++; $display("FAIL glitch3_pulse: got %0d want %0d", n_short + n_long + n_double, b_pulse); end
        r = cyc + 1;
        hold(1'b1, 4);
        wait_idle();
        total++; if (t_rise !== r + 5) begin bad++; $display("FAIL glitch4_rise: got %0d want %0d", t_rise, r + 5); end
        total++; if (n_short !== b_short + 1) begin bad++; $display("FAIL glitch4_short: got %0d want %0d", n_short, b_short + 1); end
    endtask

    task automatic test_short();
        int b_short, b_long, b_double, r;
        b_short = n_short; b_long = n_long; b_double = n_double;
        r = cyc + 1;
        hold(1'b1, 10);
        hold(1'b0, 11);
        // After edge r+20: in GAP, no event yet
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL short_in_gap_busy: got %0b want 1", bus.busy); end
        total++; if (n_short !== b_short) begin bad++; $display("FAIL short_early: got %0d want %0d", n_short, b_short); end
        wait_idle();
        total++; if (t_rise !== r + 5) begin bad++; $display("FAIL short_rise: got %0d want %0d", t_rise, r + 5); end
        total++; if (t_fall !== r + 15) begin bad++; $display("FAIL short_fall: got %0d want %0d", t_fall, r + 15); end
        total++; if (t_short !== r + 15 + 11) begin bad++; $display("FAIL short_time: got %0d want %0d", t_short, r + 26); end
        total++; if (n_short !== b_short + 1) begin bad++; $display("FAIL short_count: got %0d want %0d", n_short, b_short + 1); end
        total++; if (n_long + n_double !== b_long + b_double) begin
            bad++; $display("FAIL short_other: got %0d want %0d", n_long + n_double, b_long + b_double); end
        total++; if (t_busy_fall !== r + 26) begin bad++; $display("FAIL short_busy_fall: got %0d want %0d", t_busy_fall, r + 26); end
    endtask

    task automatic test_long();
        int b_short, b_long, r;
        b_short = n_short; b_long = n_long;
        r = cyc + 1;
        hold(1'b1, 40);
        wait_idle();
        total++; if (t_rise !== r + 5) begin bad++; $display("FAIL long_rise: got %0d want %0d", t_rise, r + 5); end
        total++; if (t_long !== r + 26) begin bad++; $display("FAIL long_time: got %0d want %0d", t_long, r + 26); end
        total++; if (n_long !== b_long + 1) begin bad++; $display("FAIL long_count: got %0d want %0d", n_long, b_long + 1); end
        total++; if (n_short !== b_short) begin bad++; $display("FAIL long_no_short: got %0d want %0d", n_short, b_short); end
        total++; if (t_fall !== r + 45) begin bad++; $display("FAIL long_fall: got %0d want %0d", t_fall, r + 45); end
        total++; if (t_busy_fall !== r + 46) begin bad++; $display("FAIL long_busy_fall: got %0d want %0d", t_busy_fall, r + 46); end
    endtask

    task automatic test_double();
        int b_short, b_double, r;
        b_short = n_short; b_double = n_double;
        r = cyc + 1;
        hold(1'b1, 8);
        hold(1'b0, 6);
        hold(1'b1, 8);
        wait_idle();
        total++; if (n_double !== b_double + 1) begin bad++; $display("FAIL double_count: got %0d want %0d", n_double, b_double + 1); end
        total++; if (n_short !== b_short) begin bad++; $display("FAIL double_no_short: got %0d want %0d", n_short, b_short); end
        total++; if (t_double !== r + 28) begin bad++; $display("FAIL double_time: got %0d want %0d", t_double, r + 28); end
    endtask

    // Second rise lands exactly on the GAP timeout edge: PRESS2 wins.
    task automatic test_gap_edge();
        int b_short, b_double, r;
        b_short = n_short; b_double = n_double;
        r = cyc + 1;
        hold(1'b1, 8);
        hold(1'b0, 10);
        hold(1'b1, 8);
        wait_idle();
        total++; if (n_short !== b_short) begin bad++; $display("FAIL gap_edge_short: got %0d want %0d", n_short, b_short); end
        total++; if (n_double !== b_double + 1) begin bad++; $display("FAIL gap_edge_double: got %0d want %0d", n_double, b_double + 1); end
        total++; if (t_double !== r + 32) begin bad++; $display("FAIL gap_edge_time: got %0d want %0d", t_double, r + 32); end
    endtask

    // Second rise one cycle too late: two separate short presses.
    task automatic test_gap_late();
        int b_short, b_double, r;
        b_short = n_short; b_double = n_double;
        r = cyc + 1;
        hold(1'b1, 8);
        hold(1'b0, 11);
        hold(1'b1, 8);
        wait_idle();
        total++; if (n_short !== b_short + 2) begin bad++; $display("FAIL gap_late_short: got %0d want %0d", n_short, b_short + 2); end
        total++; if (n_double !== b_double) begin bad++; $display("FAIL gap_late_double: got %0d want %0d", n_double, b_double); end
        total++; if (t_short !== r + 43) begin bad++; $display("FAIL gap_late_time: got %0d want %0d", t_short, r + 43); end
    endtask

    task automatic test_reset_mid();
        int b_pulse, e1;
        hold(1'b1, 8);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_pre_busy: got %0b want 1", bus.busy); end
        #3;
        rstbtn_n = 1'b0;
        #1;
        total++; if (bus.btn_level !== 1'b0) begin bad++; $display("FAIL mid_rst_level: got %0b want 0", bus.btn_level); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %0b want 0", bus.busy); end
        total++; if ({bus.short_press, bus.long_press, bus.double_press} !== 3'b000) begin
            bad++; $display("FAIL mid_rst_pulses: got %b want 000", {bus.short_press, bus.long_press, bus.double_press}); end
        @(posedge clk);
        #1;
        rstbtn_n = 1'b1;
        b_pulse = n_short + n_long + n_double;
        e1 = cyc + 1;
        hold(1'b1, 7);
        total++; if (t_rise !== e1 + 5) begin bad++; $display("FAIL mid_rerise: got %0d want %0d", t_rise, e1 + 5); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_new_press_busy: got %0b want 1", bus.busy); end
        total++; if (n_short + n_long + n_double !== b_pulse) begin
            bad++; $display("FAIL mid_no_pulse: got %0d want %0d", n_short + n_long + n_double, b_pulse); end
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstbtn_n = 1'b0;
        bus.btn_raw = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_glitch();
        test_short();
        test_long();
        test_double();
        test_gap_edge();
        test_gap_late();
        test_reset_mid();
        total++; if (n_multi !== 0) begin bad++; $display("FAIL one_hot_pulses: got %0d want 0", n_multi); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_decoder.md
Name: button_decoder

Overview:
- Input-side counterpart to the LED blinker. The blinker drives indicator outputs; this block reads a raw push-button and turns it into clean, single-cycle event pulses.
- Pipeline: 2-flop synchroniser, then a consecutive-sample debouncer, then a press-classifier FSM.
- The FSM emits short-press, long-press and double-press pulses, for use by mode-select logic (for example, changing blink intervals).

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised samples that must disagree with btn_level before it flips; legal range ≥1.
- LONG_CYCLES, 20: hold length that classifies a press as long; legal range ≥2.
- DOUBLE_GAP, 10: maximum released gap that still allows a second press to count; legal range ≥2.
- CNT_W, 8: width of the debounce counter and the timer. All three cycle parameters must be < 2^CNT_W.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rstbtn_n, input, 1: asynchronous, active-low reset.
- btn_raw, input, 1: asynchronous button, active-high, may bounce.
- btn_level, output, 1: debounced button level.
- short_press, output, 1: one-cycle pulse for a single short press.
- long_press, output, 1: one-cycle pulse when a hold reaches LONG_CYCLES.
- double_press, output, 1: one-cycle pulse for a second press inside DOUBLE_GAP.
- busy, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rstbtn_n=0, asynchronous):
  - sync flops s1 and s2, debounce counter, timer and btn_level all go to 0.
  - FSM goes to IDLE.
  - short_press, long_press, double_press and busy are 0.
  - Reset mid-press discards any pending classification. No pulse is emitted on reset release, even if btn_raw is held high.
- Synchroniser: s1 <= btn_raw, then s2 <= s1.
- Debouncer:
  - If s2 == btn_level, the counter clears to 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1, btn_level <= s2 and the counter clears.
  - Otherwise the counter increments.
  - Latency: a clean raw edge first sampled at edge R changes btn_level at edge R+DEBOUNCE_CYCLES+1.
  - A raw glitch lasting fewer than DEBOUNCE_CYCLES cycles never changes btn_level.
- FSM: samples btn_level as a level; the timer is tcnt.
  - IDLE: if btn_level=1, go to PRESS1 with tcnt <= 0.
  - PRESS1, btn_level=0: go to GAP, tcnt <= 0.
  - PRESS1, btn_level=1 and tcnt == LONG_CYCLES-1: pulse long_press, go to HELD.
  - PRESS1, otherwise: tcnt++.
  - HELD: if btn_level=0, go to IDLE. No further pulses are emitted for the same hold.
  - GAP, btn_level=1: go to PRESS2, tcnt <= 0. This has priority over the timeout in the same cycle.
  - GAP, tcnt == DOUBLE_GAP-1: pulse short_press, go to IDLE.
  - GAP, otherwise: tcnt++.
  - PRESS2, btn_level=0: pulse double_press, go to IDLE.
  - PRESS2, tcnt == LONG_CYCLES-1: pulse double_press, go to HELD.
  - PRESS2, otherwise: tcnt++.
- Pulse timing:
  - Pulses are registered and high for exactly the one cycle following the transition edge.
  - At most one pulse is high in any cycle.
- Timer width: tcnt never wraps, because every compare value is below 2^CNT_W.
- busy is registered and equals (state != IDLE).

Decomposition:
- Shared package button_pkg holds:
  - the state enum (IDLE, PRESS1, HELD, GAP, PRESS2);
  - default constants for DEBOUNCE_CYCLES, LONG_CYCLES and DOUBLE_GAP.
- One natural sub-module, btn_debounce: the synchroniser plus debouncer, with ports clk, rstbtn_n, btn_raw, btn_level.
- The FSM stays in button_decoder.

Test Plan (defaults DEBOUNCE_CYCLES=4, LONG_CYCLES=20, DOUBLE_GAP=10):
- Glitch rejection: btn_raw high for 3 cycles, then low → btn_level stays 0 and there are no pulses. The same test with 4 cycles high → btn_level rises at edge R+5.
- Short press: btn_raw high for 10 cycles, then low indefinitely. Expected:
  - btn_level rises at R+5;
  - FSM enters GAP after the release;
  - short_press pulses once, exactly DOUBLE_GAP+1 edges after btn_level falls;
  - busy then drops to 0.
- Long press: btn_raw held high for 40 cycles. Expected:
  - btn_level rises at R+5;
  - long_press pulses once, at edge R+26;
  - no short_press on release;
  - busy falls one edge after btn_level falls.
- Double press: press for 8 cycles, release for 6 cycles, press for 8 cycles, release. Expected: one double_press on the second debounced release, and zero short_press.
- Boundary (gap priority): the second btn_level rise lands on the same edge where GAP tcnt == 9 → PRESS2 is taken, no short_press is emitted, and a double_press follows.
- Reset mid-operation: assert rstbtn_n=0 asynchronously while in PRESS1 with btn_raw held high. Expected:
  - all outputs go to 0 immediately;
  - after release with btn_raw still high, btn_level re-rises 6 edges later and a new press sequence starts from IDLE.
